adc_frame_buffer: RTL and testbench

//  Downstream stage of the 8-byte ADC packer. Accepts the packer's 64-bit

---
 rtl/adc_frame_buffer.sv | 116 +++++++++++
 tb/tb_adc_frame_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/adc_frame_buffer.sv
// Frame capture buffer behind the 8-byte ADC packer: one armed frame of
// FRAME_WORDS words goes into a circular FIFO that the host reader drains.
module adc_frame_buffer #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 6,
  parameter int FRAME_WORDS = 32
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              pack_valid,
  input  logic [DATA_W-1:0] pack_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic [1:0]        state,
  output logic              frame_done,
  output logic              overflow
);
  localparam int              DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     FW    = 16'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DRAIN = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [15:0]         cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic                wr_req, wr_acc, rd_acc;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    rd_acc = rd_en && (level_q != '0);
    wr_req = pack_valid && (state_q == S_ARMED || state_q == S_CAPTURE);
    // A full FIFO still takes a word when the same cycle frees a slot.
    wr_acc = wr_req && ((level_q != FULL) || rd_acc);

    state_d      = state_q;
    cnt_d        = cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    wr_ptr_d     = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_valid_d   = rd_acc;
    rd_data_d    = rd_acc ? mem[rd_ptr_q] : rd_data_q;

    level_d = level_q;
    if (wr_acc && !rd_acc)      level_d = level_q + 1'b1;
    else if (rd_acc && !wr_acc) level_d = level_q - 1'b1;

    if (wr_req && !wr_acc) overflow_d = 1'b1;

    case (state_q)
      S_IDLE: if (arm) begin
        state_d    = S_ARMED;
        cnt_d      = '0;
        overflow_d = 1'b0;
      end
      S_ARMED, S_CAPTURE: if (pack_valid) begin
        // Dropped words still count so every frame is FRAME_WORDS inputs long.
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == FW) ? S_DRAIN : S_CAPTURE;
      end
      S_DRAIN: if (level_q == '0) begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage carries no reset; emptiness is defined by the pointers and level.
  always_ff @(posedge adc_clk) begin
    if (wr_acc) mem[wr_ptr_q] <= pack_data;
  end

  assign state      = state_q;
  assign level      = level_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Bench for adc_frame_buffer with a 4-deep FIFO and 6-word frames; a queue
// model checks every output after every clock edge.
module tb_adc_frame_buffer;
  localparam int DATA_W = 64, ADDR_W = 2, FW = 6, DEPTH = 4;

  logic              adc_clk = 1'b0, rst_n = 1'b0;
  logic              arm = 1'b0, pack_valid = 1'b0, rd_en = 1'b0;
  logic [DATA_W-1:0] pack_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, frame_done, overflow;
  logic [ADDR_W:0]   level;
  logic [1:0]        state;

  int checks = 0, errors = 0;

  // Reference model: frame state by name, FIFO as a queue.
  int                m_state;
  int                m_cnt;
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_rdd;
  logic              m_rdv, m_fd, m_ovf;

  adc_frame_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_WORDS(FW)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .arm(arm), .pack_valid(pack_valid),
    .pack_data(pack_data), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .state(state), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_q.delete();
    m_rdd = '0; m_rdv = 1'b0; m_fd = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_state));
    chk("level", 64'(level), 64'(m_q.size()));
    chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
    chk("rd_data", rd_data, m_rdd);
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic a, input logic pv, input logic [DATA_W-1:0] d, input logic r);
    bit pop, push, capt;
    int sz;
    arm = a; pack_valid = pv; pack_data = d; rd_en = r;
    @(posedge adc_clk);
    sz   = m_q.size();
    pop  = r && sz > 0;
    capt = pv && (m_state == 1 || m_state == 2);
    push = capt && (sz < DEPTH || pop);
    m_fd = (m_state == 3 && sz == 0);
    if (capt && !push) m_ovf = 1'b1;
    case (m_state)
      0: if (a) begin m_state = 1; m_cnt = 0; m_ovf = 1'b0; end
      1, 2: if (pv) begin m_cnt++; m_state = (m_cnt == FW) ? 3 : 2; end
      3: if (sz == 0) m_state = 0;
      default: ;
    endcase
    m_rdv = pop;
    if (pop) m_rdd = m_q.pop_front();
    if (push) m_q.push_back(d);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_state", 64'(state), 64'd0);
    rst_n = 1'b1;
    @(negedge adc_clk);
    step(0, 0, '0, 0);

    // Arm without data: stays ARMED.
    step(1, 0, '0, 0);
    repeat (3) step(0, 0, '0, 0);
    chk("armed_hold", 64'(state), 64'd1);

    // Six words into a four-deep FIFO: last two dropped.
    for (int i = 1; i <= 6; i++) step(0, 1, {8{8'(i * 8'h11)}}, 0);
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_state", 64'(state), 64'd3);
    step(0, 1, 64'hdead, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, '0, 1);
      chk("drain_word", rd_data, {8{8'(i * 8'h11)}});
    end
    step(0, 0, '0, 0);
    chk("frame_done", 64'(frame_done), 64'd1);
    step(0, 0, '0, 0);

    // New arm clears overflow; fill, then write+read while full.
    step(1, 1, 64'hbad, 0);
    chk("arm_clears_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 64'h100 + 64'(i), 0);
    step(0, 1, 64'h104, 1);
    chk("full_rw_level", 64'(level), 64'd4);
    chk("full_rw_ovf", 64'(overflow), 64'd0);
    step(0, 1, 64'h105, 1);
    repeat (6) step(0, 0, '0, 1);

    // Empty read, arm during capture, reset mid-capture.
    step(0, 0, '0, 1);
    chk("empty_rd_valid", 64'(rd_valid), 64'd0);
    step(1, 0, '0, 0);
    step(0, 1, 64'h200, 0);
    step(0, 1, 64'h201, 0);
    step(1, 0, '0, 0);
    chk("arm_in_capture", 64'(state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge adc_clk);
    rst_n = 1'b1;
    step(0, 0, '0, 1);
    chk("post_rst_rdv", 64'(rd_valid), 64'd0);

    // Randomized frames with interleaved reads; wraps the pointers often.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(7) == 0), $urandom_range(1) == 1,
           {$urandom, $urandom}, $urandom_range(2) != 0);
    repeat (8) step(0, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end
endmodule
